pcm_sample_sequencer: RTL and testbench
=======================================

Name: pcm_sample_sequencer

Overview:
- Upstream feeder for the ADPCM decoder in the sound subsystem.
- The sound CPU programs a start page and an end page, then triggers playback.
- The block fetches ADPCM bytes from sample ROM through a valid-handshake port and presents one 4-bit nibble per decoder sample strobe: high nibble first, then low nibble.
- While idle it holds the decoder in reset so the decoder output is silent.

Parameters:
- ADDR_WIDTH, 16: sample ROM byte-address width. Must be at least 9.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_wr  in  1  one-cycle CPU register write strobe.
- cpu_addr  in  2  register select: 0 = START page, 1 = END page, 2 = TRIGGER, 3 = STOP.
- cpu_din  in  8  write data. Ignored for TRIGGER and STOP.
- sample_strobe  in  1  one-cycle pulse from the decoder's sample-rate strobe output.
- rom_rd  out  1  ROM read request. Held high until rom_valid.
- rom_addr  out  ADDR_WIDTH  ROM byte address. Stable while rom_rd is high.
- rom_data  in  8  ROM read data. Qualified by rom_valid.
- rom_valid  in  1  one-cycle pulse marking rom_data valid. Any latency of 1 cycle or more is allowed.
- nibble  out  4  ADPCM code driven to the decoder data input.
- pcm_rst  out  1  decoder reset, active-high. High whenever the block is not playing.
- busy  out  1  high from trigger until playback ends.
- done  out  1  one-cycle pulse when playback reaches its natural end.
- underrun  out  1  sticky flag: a strobe arrived before the next byte was available. Cleared by TRIGGER.

Behaviour:
- Reset values: state IDLE; rom_rd=0; rom_addr=0; nibble=0; pcm_rst=1; busy=0; done=0; underrun=0; start/end registers=0; prefetch valid=0.
- Reset mid-playback or mid-fetch aborts immediately. A rom_valid arriving after reset is ignored.
- Register writes: START and END load 8-bit page registers.
  - Start address = {start, 8'h00}, zero-extended to ADDR_WIDTH.
  - End address = {end, 8'hFF}, zero-extended to ADDR_WIDTH.
  - Writes during playback take effect at the next TRIGGER only (values are latched at trigger).
- Address arithmetic: the byte address increments modulo 2^ADDR_WIDTH. Playback ends after the byte at the end address. If end < start, playback wraps through 0.
- States:
  - IDLE:
    - pcm_rst=1, busy=0, nibble=0.
    - On TRIGGER: latch addresses, addr<=start, clear underrun, busy<=1, go to FETCH.
  - FETCH:
    - rom_rd=1, rom_addr=addr.
    - On rom_valid: cur<=rom_data, go to PLAY_HI.
    - pcm_rst falls on the cycle after rom_valid.
  - PLAY_HI:
    - On sample_strobe: nibble<=cur[7:4], go to PLAY_LO.
    - If addr != end, in the same cycle start a prefetch: rom_rd=1, rom_addr=addr+1.
  - PLAY_LO:
    - Prefetch completes on rom_valid: nxt<=rom_data, nxt_valid<=1.
    - On sample_strobe: nibble<=cur[3:0].
    - If addr==end: go to DRAIN.
    - Else if nxt_valid: cur<=nxt, addr<=addr+1, nxt_valid<=0, go to PLAY_HI.
    - Else (underrun): underrun<=1, addr<=addr+1, go to STALL.
  - STALL:
    - The prefetch request remains outstanding.
    - Each strobe while stalled drives nibble<=0.
    - On rom_valid: cur<=rom_data, go to PLAY_HI.
  - DRAIN:
    - On the next sample_strobe: nibble<=0, pcm_rst<=1, busy<=0, done pulses for one cycle, go to IDLE.
- Latency: the first high nibble appears on the first strobe after the FETCH rom_valid. After that, exactly one nibble changes per strobe.
- Simultaneous sample_strobe and rom_valid in PLAY_LO: the arriving byte counts as available. No underrun; cur<=rom_data directly.
- TRIGGER while busy: restart from the new start address and clear underrun.
  - If a ROM request is outstanding, keep rom_rd/rom_addr until rom_valid and discard that data, then go to FETCH.
  - Otherwise go to FETCH on the next cycle.
  - pcm_rst pulses high for at least one cycle; done is not pulsed.
- STOP: same outstanding-request rule as TRIGGER, then go to IDLE. done is not pulsed.
- STOP while IDLE: no effect.
- cpu_wr coincident with sample_strobe: the register write takes priority; the strobe is ignored.
- rom_rd deasserts in the cycle following rom_valid. A request is never reissued until its valid has been received.

Decomposition:
- Shared sound package holds:
  - the state enumeration (IDLE, FETCH, PLAY_HI, PLAY_LO, STALL, DRAIN);
  - register-select constants REG_START=0, REG_END=1, REG_TRIGGER=2, REG_STOP=3;
  - the page-to-address helper constants (low byte 8'h00 / 8'hFF).
- One natural sub-module, pcm_rom_req: the single-outstanding request/valid tracker, with a discard-on-abort flag.

Test Plan:
- START=0x12, END=0x12, TRIGGER; ROM returns 0xA5 then 0x3C with latency 3 → rom_addr sequence 0x1200, 0x1201; nibbles per strobe A,5,3,C; ...; after byte 0x12FF's low nibble, the next strobe → nibble 0, pcm_rst=1, done one pulse.
- START=0xFF, END=0x00 (ADDR_WIDTH=16) → addresses 0xFFFF wraps to 0x0000, playback ends after 0x00FF, busy falls.
- ROM latency longer than the strobe period during a prefetch → underrun=1; strobes output 0 while stalled; playback resumes with the late byte's high nibble; underrun remains set until the next TRIGGER.
- TRIGGER issued while a prefetch is outstanding → the old rom_valid data is discarded; the next rom_addr equals the new start; no done pulse.
- STOP mid-playback, then rst_n pulled low mid-FETCH → IDLE; nibble=0; pcm_rst=1; busy=0; a late rom_valid causes no state change.
- rom_valid coincident with sample_strobe in PLAY_LO → no underrun; the next strobe outputs the new byte's high nibble.

Source files
------------

// File: rtl/pcm_sample_sequencer_pkg.sv
// Shared sound-subsystem definitions for the PCM sample sequencer:
// FSM states, CPU register map and the fill bytes used for page addresses.
package pcm_sample_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PLAY_HI,
        PLAY_LO,
        STALL,
        DRAIN
    } seq_state_t;

    localparam logic [1:0] REG_START   = 2'd0;
    localparam logic [1:0] REG_END     = 2'd1;
    localparam logic [1:0] REG_TRIGGER = 2'd2;
    localparam logic [1:0] REG_STOP    = 2'd3;

    localparam logic [7:0] PAGE_FIRST_BYTE = 8'h00;
    localparam logic [7:0] PAGE_LAST_BYTE  = 8'hFF;

endpackage

// File: rtl/pcm_sample_sequencer_rom_req.sv
// Single-outstanding ROM request tracker. An aborted request is still held
// until its valid arrives, and that returning data is swallowed.
module pcm_rom_req #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  abort,
    input  logic                  rom_valid,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  pending,
    output logic                  data_valid
);

    logic discard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            discard  <= 1'b0;
        end else if (rom_rd) begin
            if (rom_valid) begin
                rom_rd  <= 1'b0;
                discard <= 1'b0;
            end else if (abort) begin
                discard <= 1'b1;
            end
        end else if (req) begin
            rom_rd   <= 1'b1;
            rom_addr <= req_addr;
            discard  <= 1'b0;
        end
    end

    assign pending    = rom_rd;
    assign data_valid = rom_rd & rom_valid & ~discard;

endmodule

// File: rtl/pcm_sample_sequencer.sv
// Feeds ADPCM nibbles from sample ROM to the decoder, one per sample strobe,
// high nibble first, with a one-byte prefetch and decoder reset while idle.
module pcm_sample_sequencer
    import pcm_sample_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_wr,
    input  logic [1:0]            cpu_addr,
    input  logic [7:0]            cpu_din,
    input  logic                  sample_strobe,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    input  logic                  rom_valid,
    output logic [3:0]            nibble,
    output logic                  pcm_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    seq_state_t            state;
    logic [7:0]            start_page;
    logic [7:0]            end_page;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [7:0]            cur;
    logic [7:0]            nxt;
    logic                  nxt_valid;

    logic                  cmd_trig;
    logic                  cmd_stop;
    logic                  strobe;
    logic                  req;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  pending;
    logic                  data_valid;

    // A CPU write in the same cycle as a strobe wins; the strobe is dropped.
    always_comb begin
        cmd_trig = cpu_wr && (cpu_addr == REG_TRIGGER);
        cmd_stop = cpu_wr && (cpu_addr == REG_STOP) && (state != IDLE);
        strobe   = sample_strobe && !cpu_wr;
        req      = 1'b0;
        req_addr = addr;
        if (!cmd_trig && !cmd_stop) begin
            if (state == FETCH && !pending) begin
                req = 1'b1;
            end else if (state == PLAY_HI && strobe && addr != end_addr) begin
                req      = 1'b1;
                req_addr = addr + ADDR_WIDTH'(1);
            end
        end
    end

    pcm_rom_req #(.ADDR_WIDTH(ADDR_WIDTH)) u_rom_req (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_addr   (req_addr),
        .abort      (cmd_trig | cmd_stop),
        .rom_valid  (rom_valid),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .pending    (pending),
        .data_valid (data_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_page <= '0;
            end_page   <= '0;
            addr       <= '0;
            end_addr   <= '0;
            cur        <= '0;
            nxt        <= '0;
            nxt_valid  <= 1'b0;
            nibble     <= '0;
            pcm_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cpu_wr && cpu_addr == REG_START) start_page <= cpu_din;
            if (cpu_wr && cpu_addr == REG_END)   end_page   <= cpu_din;

            // Restart/stop never wait here: an in-flight fetch is discarded by the tracker,
            // and FETCH holds off its own request until the tracker is free.
            if (cmd_trig) begin
                addr      <= ADDR_WIDTH'({start_page, PAGE_FIRST_BYTE});
                end_addr  <= ADDR_WIDTH'({end_page, PAGE_LAST_BYTE});
                underrun  <= 1'b0;
                busy      <= 1'b1;
                pcm_rst   <= 1'b1;
                nibble    <= '0;
                nxt_valid <= 1'b0;
                state     <= FETCH;
            end else if (cmd_stop) begin
                busy      <= 1'b0;
                pcm_rst   <= 1'b1;
                nibble    <= '0;
                nxt_valid <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: ;
                    FETCH: begin
                        if (data_valid) begin
                            cur     <= rom_data;
                            pcm_rst <= 1'b0;
                            state   <= PLAY_HI;
                        end
                    end
                    PLAY_HI: begin
                        if (strobe) begin
                            nibble <= cur[7:4];
                            state  <= PLAY_LO;
                        end
                    end
                    PLAY_LO: begin
                        if (strobe) begin
                            nibble <= cur[3:0];
                            if (addr == end_addr) begin
                                state <= DRAIN;
                            end else begin
                                addr <= addr + ADDR_WIDTH'(1);
                                if (nxt_valid || data_valid) begin
                                    cur       <= nxt_valid ? nxt : rom_data;
                                    nxt_valid <= 1'b0;
                                    state     <= PLAY_HI;
                                end else begin
                                    underrun <= 1'b1;
                                    state    <= STALL;
                                end
                            end
                        end else if (data_valid) begin
                            nxt       <= rom_data;
                            nxt_valid <= 1'b1;
                        end
                    end
                    STALL: begin
                        if (strobe) nibble <= '0;
                        if (data_valid) begin
                            cur   <= rom_data;
                            state <= PLAY_HI;
                        end
                    end
                    DRAIN: begin
                        if (strobe) begin
                            nibble  <= '0;
                            pcm_rst <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcm_sample_sequencer.sv
// Bench for pcm_sample_sequencer: random strobe/ROM-latency playback against
// a nibble-stream model, plus directed restart, stop and reset scenarios.
module tb_pcm_sample_sequencer;

    localparam int unsigned AW = 16;
    localparam logic [1:0] A_START = 2'd0;
    localparam logic [1:0] A_END   = 2'd1;
    localparam logic [1:0] A_TRIG  = 2'd2;
    localparam logic [1:0] A_STOP  = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_wr;
    logic [1:0]    cpu_addr;
    logic [7:0]    cpu_din;
    logic          sample_strobe;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_valid;
    logic [3:0]    nibble;
    logic          pcm_rst;
    logic          busy;
    logic          done;
    logic          underrun;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    pcm_sample_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_din       (cpu_din),
        .sample_strobe (sample_strobe),
        .rom_rd        (rom_rd),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .rom_valid     (rom_valid),
        .nibble        (nibble),
        .pcm_rst       (pcm_rst),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun)
    );

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] dat);
        cpu_wr = 1'b1; cpu_addr = a; cpu_din = dat;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        sample_strobe = s; rom_valid = v; rom_data = d;
        @(posedge clk); #1;
        sample_strobe = 1'b0; rom_valid = 1'b0;
    endtask

    // Expected nibble stream: byte k's high nibble appears on the first strobe strictly
    // after both its arrival and the previous low nibble; earlier strobes give 0.
    task automatic test_playback(input string tag, input logic [7:0] sp, input logic [7:0] ep,
                                 input int unsigned pmin, input int unsigned pmax,
                                 input int unsigned lmin, input int unsigned lmax);
        logic [15:0] sa, ea, diff, trk_addr;
        int unsigned n, nib_idx, k_req, now, sc, cnt, post, k, budget;
        int unsigned arr[$];
        logic trk, fin, e_under, e_done, s, v;
        logic [3:0] e_nib;
        logic [7:0] d, b;
        sa = {sp, 8'h00}; ea = {ep, 8'hFF}; diff = ea - sa; n = int'(diff) + 1;
        nib_idx = 0; k_req = 0; now = 0; post = 0; cnt = 0;
        trk = 1'b0; fin = 1'b0; e_under = 1'b0; e_nib = 4'h0; trk_addr = '0;
        budget = (2 * n + 4) * (pmax + lmax + 2) + 50;
        sc = $urandom_range(pmax, 0);

        cpu_write(A_START, sp);
        cpu_write(A_END, ep);
        cpu_write(A_TRIG, 8'h00);
        compared++;
        if ({busy, pcm_rst, underrun, done} !== 4'b1100) begin
            mismatched++;
            $display("FAIL %s_trigger: busy,pcm_rst,underrun,done=%b required 1100", tag, {busy, pcm_rst, underrun, done});
        end

        for (int unsigned c = 0; c < budget && post < 8; c++) begin
            s = (sc == 0);
            if (s) sc = $urandom_range(pmax, pmin) - 1; else sc--;
            v = 1'b0; d = 8'h00;
            if (trk) begin
                if (cnt == 0) begin v = 1'b1; d = mem[trk_addr]; trk = 1'b0; end
                else cnt--;
            end
            cyc(s, v, d);
            now++;
            e_done = 1'b0;
            if (v) arr.push_back(now);
            if (s && !fin) begin
                if (nib_idx == 2 * n) begin
                    e_nib = 4'h0; e_done = 1'b1; fin = 1'b1;
                end else begin
                    k = nib_idx / 2;
                    b = mem[16'(sa + k)];
                    if (nib_idx % 2 == 0) begin
                        if (arr.size() > k && arr[k] < now) begin e_nib = b[7:4]; nib_idx++; end
                        else e_nib = 4'h0;
                    end else begin
                        e_nib = b[3:0]; nib_idx++;
                        if (k + 1 < n && !(arr.size() > k + 1 && arr[k + 1] <= now)) e_under = 1'b1;
                    end
                end
            end
            if (fin) post++;

            compared++;
            if (nibble !== e_nib) begin
                mismatched++;
                $display("FAIL %s_nibble @%0d: got %h required %h", tag, now, nibble, e_nib);
            end
            compared++;
            if (busy !== !fin) begin
                mismatched++;
                $display("FAIL %s_busy @%0d: got %b required %b", tag, now, busy, !fin);
            end
            compared++;
            if (pcm_rst !== (arr.size() == 0 || fin)) begin
                mismatched++;
                $display("FAIL %s_pcm_rst @%0d: got %b required %b", tag, now, pcm_rst, (arr.size() == 0 || fin));
            end
            compared++;
            if (done !== e_done) begin
                mismatched++;
                $display("FAIL %s_done @%0d: got %b required %b", tag, now, done, e_done);
            end
            compared++;
            if (underrun !== e_under) begin
                mismatched++;
                $display("FAIL %s_underrun @%0d: got %b required %b", tag, now, underrun, e_under);
            end

            if (trk) begin
                compared++;
                if (rom_rd !== 1'b1 || rom_addr !== trk_addr) begin
                    mismatched++;
                    $display("FAIL %s_rom_hold @%0d: rd=%b addr=%h required rd=1 addr=%h", tag, now, rom_rd, rom_addr, trk_addr);
                end
            end else if (rom_rd === 1'b1) begin
                compared++;
                if (k_req >= n || rom_addr !== 16'(sa + k_req)) begin
                    mismatched++;
                    $display("FAIL %s_rom_addr @%0d: got %h required %h (request %0d of %0d)", tag, now, rom_addr, 16'(sa + k_req), k_req, n);
                end
                trk = 1'b1; trk_addr = rom_addr; cnt = $urandom_range(lmax, lmin) - 1; k_req++;
            end
        end
        compared++;
        if (post < 8) begin
            mismatched++;
            $display("FAIL %s_timeout: playback incomplete, nibble index %0d required %0d", tag, nib_idx, 2 * n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_wr = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00;
        sample_strobe = 1'b0; rom_valid = 1'b0; rom_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (rom_rd !== 1'b0) begin mismatched++; $display("FAIL reset_rom_rd: got %b required 0", rom_rd); end
        compared++; if (rom_addr !== 16'h0000) begin mismatched++; $display("FAIL reset_rom_addr: got %h required 0000", rom_addr); end
        compared++; if (nibble !== 4'h0) begin mismatched++; $display("FAIL reset_nibble: got %h required 0", nibble); end
        compared++; if (pcm_rst !== 1'b1) begin mismatched++; $display("FAIL reset_pcm_rst: got %b required 1", pcm_rst); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b required 0", done); end
        compared++; if (underrun !== 1'b0) begin mismatched++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if ({busy, pcm_rst, rom_rd} !== 3'b010) begin
            mismatched++;
            $display("FAIL reset_release: busy,pcm_rst,rom_rd=%b required 010", {busy, pcm_rst, rom_rd});
        end
    endtask

    task automatic test_basic();
        mem[16'h1200] = 8'hA5;
        mem[16'h1201] = 8'h3C;
        test_playback("basic", 8'h12, 8'h12, 6, 10, 3, 3);
    endtask

    task automatic test_wrap();
        test_playback("wrap", 8'hFF, 8'h00, 5, 8, 1, 3);
    endtask

    task automatic test_underrun();
        test_playback("underrun", 8'h40, 8'h40, 4, 4, 1, 8);
        compared++;
        if (underrun !== 1'b1) begin mismatched++; $display("FAIL underrun_sticky: got %b required 1", underrun); end
    endtask

    task automatic test_coincident();
        test_playback("coincident", 8'h7E, 8'h7E, 5, 5, 5, 5);
        compared++;
        if (underrun !== 1'b0) begin mismatched++; $display("FAIL coincident_underrun: got %b required 0", underrun); end
    endtask

    task automatic test_retrigger_stop();
        mem[16'h3000] = 8'h4B;
        cpu_write(A_START, 8'h20);
        cpu_write(A_END, 8'h21);
        cpu_write(A_TRIG, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        compared++;
        if (rom_rd !== 1'b1 || rom_addr !== 16'h2000) begin mismatched++; $display("FAIL retrig_fetch: rd=%b addr=%h required 1/2000", rom_rd, rom_addr); end
        cyc(1'b0, 1'b1, mem[16'h2000]);
        cyc(1'b1, 1'b0, 8'h00);
        compared++;
        if (nibble !== mem[16'h2000][7:4] || rom_rd !== 1'b1 || rom_addr !== 16'h2001) begin
            mismatched++;
            $display("FAIL retrig_prefetch: nibble=%h rd=%b addr=%h required %h/1/2001", nibble, rom_rd, rom_addr, mem[16'h2000][7:4]);
        end
        cpu_write(A_START, 8'h30);
        cpu_write(A_TRIG, 8'h00);
        compared++;
        if ({busy, pcm_rst, done, underrun, rom_rd} !== 5'b11001 || rom_addr !== 16'h2001) begin
            mismatched++;
            $display("FAIL retrig_hold: busy,pcm_rst,done,underrun,rd=%b addr=%h required 11001/2001", {busy, pcm_rst, done, underrun, rom_rd}, rom_addr);
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'hEE);
        compared++;
        if ({rom_rd, pcm_rst, done} !== 3'b010) begin
            mismatched++;
            $display("FAIL retrig_discard: rd,pcm_rst,done=%b required 010", {rom_rd, pcm_rst, done});
        end
        cyc(1'b0, 1'b0, 8'h00);
        compared++;
        if (rom_rd !== 1'b1 || rom_addr !== 16'h3000) begin mismatched++; $display("FAIL retrig_new_start: rd=%b addr=%h required 1/3000", rom_rd, rom_addr); end
        cyc(1'b0, 1'b1, mem[16'h3000]);
        cyc(1'b1, 1'b0, 8'h00);
        compared++;
        if (nibble !== 4'h4 || done !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL retrig_first_nibble: nibble=%h done=%b busy=%b required 4/0/1", nibble, done, busy);
        end
        cpu_write(A_STOP, 8'h00);
        compared++;
        if ({busy, pcm_rst, done, rom_rd} !== 4'b0101 || nibble !== 4'h0 || rom_addr !== 16'h3001) begin
            mismatched++;
            $display("FAIL stop_hold: busy,pcm_rst,done,rd=%b nibble=%h addr=%h required 0101/0/3001", {busy, pcm_rst, done, rom_rd}, nibble, rom_addr);
        end
        cyc(1'b0, 1'b1, 8'h99);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            compared++;
            if ({rom_rd, busy, done, pcm_rst} !== 4'b0001 || nibble !== 4'h0) begin
                mismatched++;
                $display("FAIL stop_idle[%0d]: rd,busy,done,pcm_rst=%b nibble=%h required 0001/0", i, {rom_rd, busy, done, pcm_rst}, nibble);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        cpu_write(A_START, 8'h50);
        cpu_write(A_TRIG, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        compared++;
        if (rom_rd !== 1'b1 || rom_addr !== 16'h5000) begin mismatched++; $display("FAIL rstfetch_req: rd=%b addr=%h required 1/5000", rom_rd, rom_addr); end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({rom_rd, busy, pcm_rst, done} !== 4'b0010 || nibble !== 4'h0) begin
            mismatched++;
            $display("FAIL rstfetch_async: rd,busy,pcm_rst,done=%b nibble=%h required 0010/0", {rom_rd, busy, pcm_rst, done}, nibble);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({rom_rd, busy, pcm_rst, done, underrun} !== 5'b00100 || nibble !== 4'h0) begin
                mismatched++;
                $display("FAIL rstfetch_late_valid[%0d]: rd,busy,pcm_rst,done,underrun=%b nibble=%h required 00100/0", i, {rom_rd, busy, pcm_rst, done, underrun}, nibble);
            end
            cyc(1'b1, 1'b0, 8'h00);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_underrun();
        test_coincident();
        test_retrigger_stop();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
